// File: rtl/ex_muldiv_unit_pkg.sv
// ex_muldiv_unit_pkg
// Shared definitions for the EX-stage multiply/divide unit:
//   - funct codes for the HI/LO move and multiply/divide instructions
//   - FSM state encoding used by the top level
//   - small decode helpers for the funct field
package ex_muldiv_unit_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // True for any of the four iterative multiply/divide operations
  function automatic logic is_muldiv_fn(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

  // True for DIV/DIVU
  function automatic logic is_div_fn(input logic [5:0] f);
    return (f == FN_DIV) || (f == FN_DIVU);
  endfunction

  // True for the signed variants MULT/DIV
  function automatic logic is_signed_fn(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_DIV);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_md_iter_core.sv
// md_iter_core
// Unsigned iterative datapath: one shift-add multiply step or one restoring
// divide step per enabled cycle, WIDTH steps per operation.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           load operands and clear the step counter
//   step            perform one iteration this cycle
//   is_div          1 = restoring divide, 0 = shift-add multiply (held by caller)
//   load_lower      multiplier (mul) or dividend (div), unsigned magnitude
//   load_mcand      multiplicand (mul) or divisor (div), unsigned magnitude
//   done            high during the final step
//   res_upper       value upper half takes at this edge (product high / remainder)
//   res_lower       value lower half takes at this edge (product low / quotient)
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] load_lower,
  input  logic [WIDTH-1:0] load_mcand,
  output logic             done,
  output logic [WIDTH-1:0] res_upper,
  output logic [WIDTH-1:0] res_lower
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] upper_r;
  logic [WIDTH-1:0] lower_r;
  logic [WIDTH-1:0] mcand_r;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH:0]   rem_diff_s;
  logic [WIDTH-1:0] nxt_upper_s;
  logic [WIDTH-1:0] nxt_lower_s;

  // One iteration of either algorithm; results are the post-step register values
  always_comb begin
    mul_sum_s   = {1'b0, upper_r} +
                  (lower_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    // Partial remainder shifted left, pulling in the next dividend bit
    rem_sh_s    = {upper_r, lower_r[WIDTH-1]};
    rem_diff_s  = rem_sh_s - {1'b0, mcand_r};
    nxt_upper_s = upper_r;
    nxt_lower_s = lower_r;
    if (is_div) begin
      if (rem_sh_s >= {1'b0, mcand_r}) begin
        nxt_upper_s = rem_diff_s[WIDTH-1:0];
        nxt_lower_s = {lower_r[WIDTH-2:0], 1'b1};
      end else begin
        nxt_upper_s = rem_sh_s[WIDTH-1:0];
        nxt_lower_s = {lower_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Shift the sum right; the consumed multiplier bit falls off the bottom
      nxt_upper_s = mul_sum_s[WIDTH:1];
      nxt_lower_s = {mul_sum_s[0], lower_r[WIDTH-1:1]};
    end
  end

  assign done      = step && (cnt_r == CW'(WIDTH-1));
  assign res_upper = nxt_upper_s;
  assign res_lower = nxt_lower_s;

  // Operand load, per-step update and iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      upper_r <= {WIDTH{1'b0}};
      lower_r <= {WIDTH{1'b0}};
      mcand_r <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else if (start) begin
      upper_r <= {WIDTH{1'b0}};
      lower_r <= load_lower;
      mcand_r <= load_mcand;
      cnt_r   <= {CW{1'b0}};
    end else if (step) begin
      upper_r <= nxt_upper_s;
      lower_r <= nxt_lower_s;
      cnt_r   <= cnt_r + CW'(1);
    end else begin
      upper_r <= upper_r;
      lower_r <= lower_r;
      mcand_r <= mcand_r;
      cnt_r   <= cnt_r;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
// Runs MULT/MULTU/DIV/DIVU iteratively (WIDTH steps) and serves MFHI/MFLO/
// MTHI/MTLO. Stalls the front end while an operation is in flight.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   valid_in   ID/EX holds a live SPECIAL instruction
//   funct      ID/EX funct field
//   rs_val     dividend / multiplicand / MTHI-MTLO source
//   rt_val     divisor / multiplier
//   stall      hold PC, IF/ID, ID/EX (combinational)
//   mf_valid   current instruction is MFHI/MFLO
//   mf_data    HI for MFHI, LO for MFLO, else zero
//   hi, lo     architectural HI/LO
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             stall,
  output logic             mf_valid,
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t           state_r;
  state_t           nxt_state_s;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] nxt_hi_s;
  logic [WIDTH-1:0] nxt_lo_s;
  logic             div_r;
  logic             neg_main_r;  // negate product (mul) or quotient (div)
  logic             neg_rem_r;   // negate remainder (div only)

  logic             op_md_s;
  logic             op_div_s;
  logic             op_signed_s;
  logic             rs_neg_s;
  logic             rt_neg_s;
  logic [WIDTH-1:0] rs_mag_s;
  logic [WIDTH-1:0] rt_mag_s;

  logic             start_s;
  logic             step_s;
  logic             core_done_s;
  logic [WIDTH-1:0] core_upper_s;
  logic [WIDTH-1:0] core_lower_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_neg_s;
  logic [WIDTH-1:0] fin_hi_s;
  logic [WIDTH-1:0] fin_lo_s;

  assign op_md_s     = valid_in && is_muldiv_fn(funct);
  assign op_div_s    = is_div_fn(funct);
  assign op_signed_s = is_signed_fn(funct);
  assign rs_neg_s    = op_signed_s && rs_val[WIDTH-1];
  assign rt_neg_s    = op_signed_s && rt_val[WIDTH-1];
  // Magnitude of the most negative value is itself, read as unsigned
  assign rs_mag_s    = rs_neg_s ? ({WIDTH{1'b0}} - rs_val) : rs_val;
  assign rt_mag_s    = rt_neg_s ? ({WIDTH{1'b0}} - rt_val) : rt_val;

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .rst        (rst),
    .start      (start_s),
    .step       (step_s),
    .is_div     (div_r),
    .load_lower (op_div_s ? rs_mag_s : rt_mag_s),
    .load_mcand (op_div_s ? rt_mag_s : rs_mag_s),
    .done       (core_done_s),
    .res_upper  (core_upper_s),
    .res_lower  (core_lower_s)
  );

  // Sign correction of the unsigned core result
  always_comb begin
    prod_s     = {core_upper_s, core_lower_s};
    prod_neg_s = {(2*WIDTH){1'b0}} - prod_s;
    if (div_r) begin
      fin_lo_s = neg_main_r ? ({WIDTH{1'b0}} - core_lower_s) : core_lower_s;
      fin_hi_s = neg_rem_r  ? ({WIDTH{1'b0}} - core_upper_s) : core_upper_s;
    end else begin
      // Product is negated across the full double width, not per half
      fin_hi_s = neg_main_r ? prod_neg_s[2*WIDTH-1:WIDTH] : prod_s[2*WIDTH-1:WIDTH];
      fin_lo_s = neg_main_r ? prod_neg_s[WIDTH-1:0]       : prod_s[WIDTH-1:0];
    end
  end

  // Control FSM: stall generation, core sequencing and HI/LO next values
  always_comb begin
    nxt_state_s = state_r;
    nxt_hi_s    = hi_r;
    nxt_lo_s    = lo_r;
    stall       = 1'b0;
    start_s     = 1'b0;
    step_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (op_md_s) begin
          stall = 1'b1;
          if (op_div_s && (rt_val == {WIDTH{1'b0}})) begin
            // Divide by zero resolves immediately without iterating
            nxt_state_s = ST_DONE;
            nxt_lo_s    = {WIDTH{1'b1}};
            nxt_hi_s    = rs_val;
          end else begin
            nxt_state_s = ST_BUSY;
            start_s     = 1'b1;
          end
        end else if (valid_in && (funct == FN_MTHI)) begin
          nxt_hi_s = rs_val;
        end else if (valid_in && (funct == FN_MTLO)) begin
          nxt_lo_s = rs_val;
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        stall  = 1'b1;
        step_s = 1'b1;
        if (core_done_s) begin
          nxt_state_s = ST_DONE;
          nxt_hi_s    = fin_hi_s;
          nxt_lo_s    = fin_lo_s;
        end else begin
          nxt_state_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        // Instruction still sits in ID/EX this cycle; ignore it so it can leave
        nxt_state_s = ST_IDLE;
      end
      default: begin
        nxt_state_s = ST_IDLE;
      end
    endcase
  end

  // MF read mux from current HI/LO
  always_comb begin
    mf_valid = valid_in && ((funct == FN_MFHI) || (funct == FN_MFLO));
    if (valid_in && (funct == FN_MFHI)) begin
      mf_data = hi_r;
    end else if (valid_in && (funct == FN_MFLO)) begin
      mf_data = lo_r;
    end else begin
      mf_data = {WIDTH{1'b0}};
    end
  end

  // State, HI/LO and result-sign flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
      div_r      <= 1'b0;
      neg_main_r <= 1'b0;
      neg_rem_r  <= 1'b0;
    end else begin
      state_r <= nxt_state_s;
      hi_r    <= nxt_hi_s;
      lo_r    <= nxt_lo_s;
      if (start_s) begin
        div_r      <= op_div_s;
        neg_main_r <= rs_neg_s ^ rt_neg_s;
        neg_rem_r  <= op_div_s && rs_neg_s;
      end else begin
        div_r      <= div_r;
        neg_main_r <= neg_main_r;
        neg_rem_r  <= neg_rem_r;
      end
    end
  end

  assign hi = hi_r;
  assign lo = lo_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (WIDTH=32).
module tb_ex_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [5:0]  funct;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        stall;
  logic        mf_valid;
  logic [31:0] mf_data;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .funct    (funct),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .stall    (stall),
    .mf_valid (mf_valid),
    .mf_data  (mf_data),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one instruction (called at posedge+1), holds it while stall is
  // high, lets it leave on the first non-stalled edge, then returns at the
  // following posedge+1 with ID/EX empty. n = number of stalled cycles.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    n = 0;
    valid_in = 1'b1; funct = f; rs_val = a; rt_val = b;
    #1;
    while (stall && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    valid_in = 1'b0; funct = 6'h00;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; funct = 6'h00; rs_val = 32'h0; rt_val = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=00000000", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=00000000", lo); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_multu();
    int n;
    issue(6'h19, 32'hFFFFFFFF, 32'h00000002, n);
    checks++; if (n !== 33) begin failures++; $display("FAIL multu_stall_len got=%0d exp=33", n); end
    checks++; if (hi !== 32'h00000001) begin failures++; $display("FAIL multu_hi got=%h exp=00000001", hi); end
    checks++; if (lo !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_lo got=%h exp=fffffffe", lo); end
  endtask

  task automatic test_mult_mflo();
    int n;
    issue(6'h18, 32'hFFFFFFFD, 32'h00000007, n);
    checks++; if (n !== 33) begin failures++; $display("FAIL mult_stall_len got=%0d exp=33", n); end
    checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFEB) begin failures++; $display("FAIL mult_lo got=%h exp=ffffffeb", lo); end
    valid_in = 1'b1; funct = 6'h12; #1;
    checks++; if (mf_valid !== 1'b1) begin failures++; $display("FAIL mflo_valid got=%b exp=1", mf_valid); end
    checks++; if (mf_data !== 32'hFFFFFFEB) begin failures++; $display("FAIL mflo_data got=%h exp=ffffffeb", mf_data); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mflo_stall got=%b exp=0", stall); end
    @(posedge clk); #1;
    valid_in = 1'b0; funct = 6'h00;
  endtask

  task automatic test_div();
    int n;
    issue(6'h1B, 32'd100, 32'd7, n);
    checks++; if (n !== 33) begin failures++; $display("FAIL divu_stall_len got=%0d exp=33", n); end
    checks++; if (lo !== 32'd14) begin failures++; $display("FAIL divu_lo got=%h exp=0000000e", lo); end
    checks++; if (hi !== 32'd2) begin failures++; $display("FAIL divu_hi got=%h exp=00000002", hi); end
    issue(6'h1A, 32'hFFFFFFF9, 32'd2, n);
    checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg_lo got=%h exp=fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_neg_hi got=%h exp=ffffffff", hi); end
    issue(6'h1A, 32'h80000000, 32'hFFFFFFFF, n);
    checks++; if (lo !== 32'h80000000) begin failures++; $display("FAIL div_wrap_lo got=%h exp=80000000", lo); end
    checks++; if (hi !== 32'h00000000) begin failures++; $display("FAIL div_wrap_hi got=%h exp=00000000", hi); end
  endtask

  task automatic test_div_zero();
    int n;
    issue(6'h1A, 32'd5, 32'd0, n);
    checks++; if (n !== 1) begin failures++; $display("FAIL divzero_stall_len got=%0d exp=1", n); end
    checks++; if (lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL divzero_lo got=%h exp=ffffffff", lo); end
    checks++; if (hi !== 32'd5) begin failures++; $display("FAIL divzero_hi got=%h exp=00000005", hi); end
  endtask

  task automatic test_mt_mf();
    logic seen_stall;
    seen_stall = 1'b0;
    valid_in = 1'b1; funct = 6'h11; rs_val = 32'h00001234; #1;
    seen_stall = seen_stall | stall;
    @(posedge clk); #1;
    funct = 6'h10; rs_val = 32'h0; #1;
    seen_stall = seen_stall | stall;
    checks++; if (mf_valid !== 1'b1) begin failures++; $display("FAIL mfhi_valid got=%b exp=1", mf_valid); end
    checks++; if (mf_data !== 32'h00001234) begin failures++; $display("FAIL mfhi_data got=%h exp=00001234", mf_data); end
    @(posedge clk); #1;
    // Non-HI/LO funct: ignored, reads zero
    funct = 6'h20; rs_val = 32'hDEADBEEF; #1;
    seen_stall = seen_stall | stall;
    checks++; if (mf_valid !== 1'b0) begin failures++; $display("FAIL other_mf_valid got=%b exp=0", mf_valid); end
    checks++; if (mf_data !== 32'h0) begin failures++; $display("FAIL other_mf_data got=%h exp=00000000", mf_data); end
    @(posedge clk); #1;
    checks++; if (hi !== 32'h00001234) begin failures++; $display("FAIL other_hi_kept got=%h exp=00001234", hi); end
    checks++; if (seen_stall !== 1'b0) begin failures++; $display("FAIL mtmf_stall got=%b exp=0", seen_stall); end
    valid_in = 1'b0; funct = 6'h00;
  endtask

  task automatic test_hold_through_done();
    int n;
    n = 0;
    valid_in = 1'b1; funct = 6'h18; rs_val = 32'd3; rt_val = 32'd4; #1;
    while (stall && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    checks++; if (n !== 33) begin failures++; $display("FAIL hold_stall_len got=%0d exp=33", n); end
    // DONE cycle with MULT still present: one more cycle stall-free
    @(posedge clk); #1;
    valid_in = 1'b0; funct = 6'h00; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL hold_no_restart got=%b exp=0", stall); end
    checks++; if (lo !== 32'd12) begin failures++; $display("FAIL hold_lo got=%h exp=0000000c", lo); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    int n;
    valid_in = 1'b1; funct = 6'h18; rs_val = 32'd9; rt_val = 32'd9;
    @(posedge clk); #1;         // edge into BUSY: 1st BUSY cycle
    repeat (9) @(posedge clk);  // now in 10th BUSY cycle
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL midop_busy_stall got=%b exp=1", stall); end
    rst = 1'b1; valid_in = 1'b0; funct = 6'h00;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL midop_stall got=%b exp=0", stall); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL midop_hi got=%h exp=00000000", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL midop_lo got=%h exp=00000000", lo); end
    @(posedge clk); #1;
    issue(6'h19, 32'd6, 32'd7, n);
    checks++; if (n !== 33) begin failures++; $display("FAIL after_rst_stall_len got=%0d exp=33", n); end
    checks++; if (lo !== 32'd42) begin failures++; $display("FAIL after_rst_lo got=%h exp=0000002a", lo); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL after_rst_hi got=%h exp=00000000", hi); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_multu();
    test_mult_mflo();
    test_div();
    test_div_zero();
    test_mt_mf();
    test_hold_through_done();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
